gpu_column_shader: RTL and testbench

- Per-pixel colour stage directly downstream of the wall lookup (distance/screen_y -> uv_y, inside_wall, above_wall).
- Driven by VGA timing, it:
  - reads the current column's wall record from a double-buffered column RAM;
  - drives the lookup;
  - fetches the texel from texture ROM;
  - emits a registered RGB332 pixel with hsync/vsync/bright delayed to match.
- Also arbitrates the column-buffer bank swap with the raycaster, in vertical blank only.

---
 rtl/gpu_column_shader.sv | 171 +++++++++++++++++
 tb/tb_gpu_column_shader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_column_shader.sv
// Per-pixel colour stage: column RAM -> wall lookup -> texture ROM -> registered RGB332,
// with syncs delayed to match and a vblank-only column-buffer bank swap handshake.
module gpu_column_shader #(
  parameter int          TEXTURE_SIZE  = 64,
  parameter int          NUM_TEXTURES  = 4,
  parameter int          H_ACTIVE      = 640,
  parameter int          V_ACTIVE      = 480,
  parameter int          COL_SHIFT     = 1,
  parameter int          ROW_SHIFT     = 1,
  parameter logic [7:0]  CEILING_COLOR = 8'h49,
  parameter logic [7:0]  FLOOR_COLOR   = 8'h24,
  localparam int         UVW           = $clog2(TEXTURE_SIZE),
  localparam int         TIDW          = $clog2(NUM_TEXTURES),
  localparam int         CAW           = $clog2(H_ACTIVE >> COL_SHIFT),
  localparam int         TAW           = TIDW + 2 * UVW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  input  logic             bright,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic             col_bank,
  output logic [CAW-1:0]   col_addr,
  input  logic [15:0]      col_distance,
  input  logic [UVW-1:0]   col_uv_x,
  input  logic [TIDW-1:0]  col_tex_id,
  input  logic             col_side,
  output logic [15:0]      lk_distance,
  output logic [9:0]       lk_screen_y,
  input  logic [UVW-1:0]   lk_uv_y,
  input  logic             lk_inside_wall,
  input  logic             lk_above_wall,
  output logic [TAW-1:0]   tex_addr,
  input  logic [7:0]       tex_data,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic [7:0]       rgb,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             blank_n
);

  localparam logic [9:0] H_LIMIT    = 10'(H_ACTIVE);
  localparam logic [9:0] VBLANK_ROW = 10'(V_ACTIVE);

  typedef enum logic {IDLE, ARMED} swap_state_e;

  // S1 side-band registers
  logic [9:0] vcount_s1_q;
  logic       bright_s1_q, hs_s1_q, vs_s1_q;
  // S2 side-band registers
  logic       inside_s2_q, above_s2_q, side_s2_q;
  logic       bright_s2_q, hs_s2_q, vs_s2_q;
  // Output registers
  logic [7:0] rgb_q, rgb_d;
  logic       hs_q, vs_q, blank_q;
  // Bank swap
  swap_state_e state_q, state_d;
  logic        bank_q, bank_d;
  logic        ack_q, ack_d;
  logic        boundary;
  logic [7:0]  shaded;

  // S0: column address, clamped to 0 outside the visible line
  always_comb begin
    col_addr = '0;
    if (!reset && hcount < H_LIMIT) col_addr = CAW'(hcount >> COL_SHIFT);
  end

  // S1: lookup inputs and texture address
  always_comb begin
    lk_distance = '0;
    lk_screen_y = '0;
    tex_addr    = '0;
    if (!reset) begin
      lk_distance = (col_distance == 16'd0) ? 16'h0001 : col_distance;
      lk_screen_y = vcount_s1_q >> ROW_SHIFT;
      tex_addr    = {col_tex_id, lk_uv_y, col_uv_x};
    end
  end

  // S2: colour select; above wins over inside if both are ever seen
  always_comb begin
    shaded = {1'b0, tex_data[7:6], 1'b0, tex_data[4:3], 1'b0, tex_data[1]};
    rgb_d  = FLOOR_COLOR;
    if (!bright_s2_q)     rgb_d = 8'h00;
    else if (above_s2_q)  rgb_d = CEILING_COLOR;
    else if (inside_s2_q) rgb_d = side_s2_q ? shaded : tex_data;
  end

  assign boundary = (vcount == VBLANK_ROW) && (hcount == '0);

  // Swap only while the request is still held at the vblank boundary
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_req) begin
          if (boundary) begin
            bank_d = ~bank_q;
            ack_d  = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (!swap_req) begin
          state_d = IDLE;
        end else if (boundary) begin
          state_d = IDLE;
          bank_d  = ~bank_q;
          ack_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vcount_s1_q <= '0;
      bright_s1_q <= 1'b0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      inside_s2_q <= 1'b0;
      above_s2_q  <= 1'b0;
      side_s2_q   <= 1'b0;
      bright_s2_q <= 1'b0;
      hs_s2_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      blank_q     <= 1'b0;
      state_q     <= IDLE;
      bank_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      vcount_s1_q <= vcount;
      bright_s1_q <= bright;
      hs_s1_q     <= hsync_in;
      vs_s1_q     <= vsync_in;
      inside_s2_q <= lk_inside_wall;
      above_s2_q  <= lk_above_wall;
      side_s2_q   <= col_side;
      bright_s2_q <= bright_s1_q;
      hs_s2_q     <= hs_s1_q;
      vs_s2_q     <= vs_s1_q;
      rgb_q       <= rgb_d;
      hs_q        <= hs_s2_q;
      vs_q        <= vs_s2_q;
      blank_q     <= bright_s2_q;
      state_q     <= state_d;
      bank_q      <= bank_d;
      ack_q       <= ack_d;
    end
  end

  assign col_bank  = bank_q;
  assign swap_ack  = ack_q;
  assign rgb       = rgb_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  assign blank_n   = blank_q;

endmodule

// File: tb/tb_gpu_column_shader.sv
// Bench for gpu_column_shader: directed pipeline/swap steps followed by randomized
// pixels scored against a frame-level reference model.
module tb_gpu_column_shader;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic        bright, hsync_in, vsync_in;
  logic        col_bank;
  logic [8:0]  col_addr;
  logic [15:0] col_distance;
  logic [5:0]  col_uv_x;
  logic [1:0]  col_tex_id;
  logic        col_side;
  logic [15:0] lk_distance;
  logic [9:0]  lk_screen_y;
  logic [5:0]  lk_uv_y;
  logic        lk_inside_wall, lk_above_wall;
  logic [13:0] tex_addr;
  logic [7:0]  tex_data;
  logic        swap_req, swap_ack;
  logic [7:0]  rgb;
  logic        hsync_out, vsync_out, blank_n;

  int tests = 0;
  int fails = 0;

  gpu_column_shader #(
    .TEXTURE_SIZE(64), .NUM_TEXTURES(4), .H_ACTIVE(640), .V_ACTIVE(480),
    .COL_SHIFT(1), .ROW_SHIFT(1), .CEILING_COLOR(8'h49), .FLOOR_COLOR(8'h24)
  ) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .bright(bright),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .col_bank(col_bank), .col_addr(col_addr),
    .col_distance(col_distance), .col_uv_x(col_uv_x), .col_tex_id(col_tex_id),
    .col_side(col_side), .lk_distance(lk_distance), .lk_screen_y(lk_screen_y),
    .lk_uv_y(lk_uv_y), .lk_inside_wall(lk_inside_wall), .lk_above_wall(lk_above_wall),
    .tex_addr(tex_addr), .tex_data(tex_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_n(blank_n)
  );

  always #5 clk = ~clk;

  // Environment: double-buffered column RAM and texture ROM, both 1-cycle reads
  logic [15:0] cm_dist [2][320];
  logic [5:0]  cm_uvx  [2][320];
  logic [1:0]  cm_tid  [2][320];
  logic        cm_side [2][320];
  logic [7:0]  tex_mem [16384];

  always @(posedge clk) begin
    col_distance <= cm_dist[col_bank][col_addr];
    col_uv_x     <= cm_uvx[col_bank][col_addr];
    col_tex_id   <= cm_tid[col_bank][col_addr];
    col_side     <= cm_side[col_bank][col_addr];
    tex_data     <= tex_mem[tex_addr];
  end

  // Wall lookup model: centred wall of height 8192/distance on a 240-row screen
  function automatic logic [7:0] lookup(input logic [15:0] d, input logic [9:0] sy);
    int unsigned h, top, s;
    logic ab, in_w;
    logic [5:0] uv;
    h = (d == 16'd0) ? 240 : 32'h2000 / {16'd0, d};
    if (h > 240) h = 240;
    top  = (240 - h) / 2;
    s    = {22'd0, sy};
    ab   = (s < top);
    in_w = !ab && (s < top + h);
    uv   = '0;
    if (in_w) uv = 6'(((s - top) * 64) / h);
    return {ab, in_w, uv};
  endfunction

  logic       ovr = 1'b0;
  logic       ovr_ab = 1'b0, ovr_in = 1'b0;
  logic [5:0] ovr_uv = '0;
  logic [7:0] lk_res;

  always_comb begin
    lk_res = lookup(lk_distance, lk_screen_y);
    if (ovr) lk_res = {ovr_ab, ovr_in, ovr_uv};
  end
  assign {lk_above_wall, lk_inside_wall, lk_uv_y} = lk_res;

  // Reference pixel for a given raster position and displayed bank
  function automatic logic [7:0] ref_pix(input int h, input int v, input bit b, input bit bank);
    int col, r, g, bl;
    logic [15:0] d;
    logic [7:0] lk, t;
    if (!b) return 8'h00;
    col = (h >= 640) ? 0 : h / 2;
    d = cm_dist[bank][col];
    if (d == 16'd0) d = 16'd1;
    lk = lookup(d, 10'(v / 2));
    if (lk[7]) return 8'h49;
    if (!lk[6]) return 8'h24;
    t = tex_mem[int'(cm_tid[bank][col]) * 4096 + int'(lk[5:0]) * 64 + int'(cm_uvx[bank][col])];
    if (!cm_side[bank][col]) return t;
    r  = int'(t[7:5]) / 2;
    g  = int'(t[4:2]) / 2;
    bl = int'(t[1:0]) / 2;
    return 8'(r * 32 + g * 4 + bl);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input bit b, input bit hs, input bit vs);
    hcount   = 10'(h);
    vcount   = 10'(v);
    bright   = b;
    hsync_in = hs;
    vsync_in = vs;
  endtask

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs, vs, bl;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   exp_bank;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int bk = 0; bk < 2; bk++) begin
      for (int c = 0; c < 320; c++) begin
        cm_dist[bk][c] = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 16'h3000));
        cm_uvx[bk][c]  = 6'($urandom_range(0, 63));
        cm_tid[bk][c]  = 2'($urandom_range(0, 3));
        cm_side[bk][c] = 1'($urandom_range(0, 1));
      end
    end
    for (int i = 0; i < 16384; i++) tex_mem[i] = 8'($urandom_range(0, 255));
    cm_dist[0][50] = 16'h0200; cm_uvx[0][50] = 6'd5; cm_tid[0][50] = 2'd2; cm_side[0][50] = 1'b0;
    cm_dist[0][51] = 16'h0200; cm_uvx[0][51] = 6'd5; cm_tid[0][51] = 2'd2; cm_side[0][51] = 1'b1;
    cm_dist[0][52] = 16'h0000; cm_uvx[0][52] = 6'd5; cm_tid[0][52] = 2'd2; cm_side[0][52] = 1'b0;
    tex_mem[14'h2445] = 8'hFF;

    // Reset held for two cycles during active video
    swap_req = 1'b0;
    reset    = 1'b1;
    drive(100, 200, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    reset = 1'b0;
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_hsync", hsync_out, 1'b0);
    chk("rst_vsync", vsync_out, 1'b0);
    chk("rst_blank", blank_n, 1'b0);
    chk("rst_bank", col_bank, 1'b0);
    chk("rst_ack", swap_ack, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // Ceiling pixel and exact 3-cycle latency
    ovr = 1'b1; ovr_ab = 1'b1; ovr_in = 1'b0; ovr_uv = '0;
    drive(100, 200, 1'b1, 1'b0, 1'b0);
    #1 chk("ceil_col_addr", col_addr, 50);
    tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    #1 chk("ceil_screen_y", lk_screen_y, 100);
    tick();
    chk("ceil_rgb_at2", rgb, 8'h00);
    tick();
    chk("ceil_rgb_at3", rgb, 8'h49);
    chk("ceil_blank_at3", blank_n, 1'b1);
    tick();
    chk("ceil_rgb_at4", rgb, 8'h00);

    // Textured wall, unshaded
    ovr_ab = 1'b0; ovr_in = 1'b1; ovr_uv = 6'd17;
    drive(100, 200, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    #1 chk("tex_addr", tex_addr, 14'h2445);
    chk("lk_distance", lk_distance, 16'h0200);
    tick(); tick();
    chk("tex_rgb", rgb, 8'hFF);

    // Textured wall, y-side shaded
    drive(102, 200, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    #1 chk("shade_tex_addr", tex_addr, 14'h2445);
    tick(); tick();
    chk("shade_rgb", rgb, 8'h6D);

    // Zero distance guard
    drive(104, 200, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    #1 chk("dist_guard", lk_distance, 16'h0001);
    tick(); tick();

    // Blanked pixel inside wall, sync pulses delayed by 3
    drive(100, 200, 1'b0, 1'b1, 1'b0);
    tick();
    drive(100, 200, 1'b0, 1'b0, 1'b1);
    tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    chk("hs_at2", hsync_out, 1'b0);
    tick();
    chk("blank_rgb", rgb, 8'h00);
    chk("blank_n_low", blank_n, 1'b0);
    chk("hs_at3", hsync_out, 1'b1);
    chk("vs_at2", vsync_out, 1'b0);
    tick();
    chk("hs_at4", hsync_out, 1'b0);
    chk("vs_at3", vsync_out, 1'b1);
    tick();
    chk("vs_at4", vsync_out, 1'b0);
    ovr = 1'b0;

    // Swap requested early in the frame, performed at the vblank boundary only
    swap_req = 1'b1;
    drive(0, 10, 1'b0, 1'b0, 1'b0);
    tick(); chk("swap_v10_bank", col_bank, 1'b0);
    drive(0, 479, 1'b0, 1'b0, 1'b0);
    tick(); chk("swap_v479_bank", col_bank, 1'b0);
    drive(5, 480, 1'b0, 1'b0, 1'b0);
    tick(); chk("swap_h5_bank", col_bank, 1'b0);
    chk("swap_h5_ack", swap_ack, 1'b0);
    drive(0, 480, 1'b0, 1'b0, 1'b0);
    tick(); chk("swap_bank", col_bank, 1'b1);
    chk("swap_ack", swap_ack, 1'b1);
    swap_req = 1'b0;
    drive(1, 480, 1'b0, 1'b0, 1'b0);
    tick(); chk("swap_ack_pulse", swap_ack, 1'b0);
    chk("swap_bank_hold", col_bank, 1'b1);

    // Request withdrawn mid-frame: no swap
    swap_req = 1'b1;
    drive(0, 10, 1'b0, 1'b0, 1'b0);
    tick();
    swap_req = 1'b0;
    drive(0, 300, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 480, 1'b0, 1'b0, 1'b0);
    tick(); chk("drop_bank", col_bank, 1'b1);
    chk("drop_ack", swap_ack, 1'b0);

    // Reset at the boundary with a pending swap drops it
    swap_req = 1'b1;
    drive(0, 100, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    drive(0, 480, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_swap_bank", col_bank, 1'b0);
    chk("rst_swap_ack", swap_ack, 1'b0);
    reset = 1'b0;
    swap_req = 1'b0;
    drive(1, 480, 1'b0, 1'b0, 1'b0);
    tick(); chk("rst_swap_ack2", swap_ack, 1'b0);
    drive(0, 480, 1'b0, 1'b0, 1'b0);
    tick(); chk("rst_swap_bank2", col_bank, 1'b0);
    chk("rst_swap_ack3", swap_ack, 1'b0);

    // Request raised exactly at the boundary swaps that cycle
    swap_req = 1'b1;
    drive(0, 480, 1'b0, 1'b0, 1'b0);
    tick(); chk("direct_bank", col_bank, 1'b1);
    chk("direct_ack", swap_ack, 1'b1);
    swap_req = 1'b0;
    drive(1, 480, 1'b0, 1'b0, 1'b0);
    tick(); chk("direct_ack_pulse", swap_ack, 1'b0);
    exp_bank = 1'b1;

    // Randomized pixels against the reference model
    for (int i = 0; i < 1500; i++) begin
      int h, v;
      bit b, hs, vs;
      h  = $urandom_range(0, 799);
      v  = $urandom_range(0, 524);
      b  = ($urandom_range(0, 3) != 0);
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      drive(h, v, b, hs, vs);
      #1 chk("rand_col_addr", col_addr, (h >= 640) ? 0 : h / 2);
      q.push_back('{ref_pix(h, v, b, exp_bank), hs, vs, b});
      tick();
      if (q.size() == 3) begin
        e = q.pop_front();
        chk("rand_rgb", rgb, e.rgb);
        chk("rand_hsync", hsync_out, e.hs);
        chk("rand_vsync", vsync_out, e.vs);
        chk("rand_blank", blank_n, e.bl);
      end
    end
    chk("rand_bank", col_bank, exp_bank);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
